// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// fc_pkg : state encoding and width helpers for the time-multiplexed FC layer
// Revision : 1.0
// ============================================================================
package fc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   // Worst case IN*(-2^(W-1))^2 fits, so the accumulator never overflows
   function automatic int acc_width(input int w, input int n);
      return 2*w + $clog2(n);
   endfunction

   function automatic int lane_sum_width(input int w, input int lanes);
      return 2*w + $clog2(lanes);
   endfunction

   // Node count on adder-tree level lvl; level 0 holds the products
   function automatic int tree_nodes(input int lanes, input int lvl);
      int n = lanes;
      for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fc_lane_dot.sv
`default_nettype none
// ============================================================================
// fc_lane_dot : LANES signed products reduced by a balanced adder tree,
//               single registered lane sum
// Revision : 1.0
// ============================================================================
module fc_lane_dot import fc_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int LANES = 8,
   localparam int SUM_W = lane_sum_width(WIDTH, LANES)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [LANES*WIDTH-1:0] i_a,
   input  logic [LANES*WIDTH-1:0] i_b,
   output logic [SUM_W-1:0]       o_sum
);

   localparam int c_levels = $clog2(LANES);

   // Every node is carried at full lane-sum width; an odd node out passes up unchanged
   for (genvar l = 0; l <= c_levels; l++) begin : g_lvl
      for (genvar j = 0; j < tree_nodes(LANES, l); j++) begin : g_node
         logic signed [SUM_W-1:0] w_s;
         if (l == 0) begin : g_leaf
            logic signed [WIDTH-1:0] w_a;
            logic signed [WIDTH-1:0] w_b;
            assign w_a = i_a[j*WIDTH +: WIDTH];
            assign w_b = i_b[j*WIDTH +: WIDTH];
            assign w_s = SUM_W'((2*WIDTH)'(w_a) * (2*WIDTH)'(w_b));
         end else if (2*j + 1 < tree_nodes(LANES, l - 1)) begin : g_add
            assign w_s = g_lvl[l-1].g_node[2*j].w_s + g_lvl[l-1].g_node[2*j+1].w_s;
         end else begin : g_pass
            assign w_s = g_lvl[l-1].g_node[2*j].w_s;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) o_sum <= '0;
      else        o_sum <= g_lvl[c_levels].g_node[0].w_s;
   end

endmodule
`default_nettype wire

// File: rtl/fc_mac_neuron_seq.sv
`default_nettype none
// ============================================================================
// fc_mac_neuron_seq : time-multiplexed FC layer, NEURONS dot products of one
//                     IN-element vector, LANES MACs per clock, external ROM.
//                     FC_RELU_EN defined -> ReLU on each result.
// Revision : 1.0
// ============================================================================
module fc_mac_neuron_seq import fc_pkg::*; #(
   parameter int WIDTH   = 8,
   parameter int IN      = 128,
   parameter int NEURONS = 10,
   parameter int LANES   = 8,
   localparam int BEATS  = IN / LANES,
   localparam int ACC_W  = acc_width(WIDTH, IN),
   localparam int AW     = idx_width(NEURONS * BEATS),
   localparam int IW     = idx_width(NEURONS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN*WIDTH-1:0]    in_x,
   output logic                   w_rd,
   output logic [AW-1:0]          w_addr,
   input  logic [LANES*WIDTH-1:0] w_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_z,
   output logic [IW-1:0]          out_idx,
   output logic                   out_last,
   output logic                   busy
);

   localparam int c_sum_w = lane_sum_width(WIDTH, LANES);
   localparam int c_bw    = idx_width(BEATS);

   state_t                      r_state;
   logic [IN*WIDTH-1:0]         r_x;
   logic [c_bw-1:0]             r_beat;
   logic [c_bw-1:0]             r_b1;
   logic [IW-1:0]               r_neuron;
   logic                        r_v1;
   logic                        r_v2;
   logic                        r_drain;
   logic signed [ACC_W-1:0]     r_acc;

   logic [LANES*WIDTH-1:0]      w_xsel;
   logic signed [c_sum_w-1:0]   w_lane;
   logic signed [ACC_W-1:0]     w_acc_next;
   logic [ACC_W-1:0]            w_res;
   logic                        w_last_beat;
   logic                        w_last_neuron;

   // r_b1 is the beat whose ROM row is arriving on w_data this cycle
   assign w_xsel        = r_x[r_b1*LANES*WIDTH +: LANES*WIDTH];
   assign w_acc_next    = r_acc + (r_v2 ? ACC_W'(w_lane) : '0);
   assign w_last_beat   = (r_beat == c_bw'(BEATS - 1));
   assign w_last_neuron = (r_neuron == IW'(NEURONS - 1));

`ifdef FC_RELU_EN
   assign w_res = w_acc_next[ACC_W-1] ? '0 : w_acc_next;
`else
   assign w_res = w_acc_next;
`endif

   fc_lane_dot #(
      .WIDTH (WIDTH),
      .LANES (LANES)
   ) u_lane_dot (
      .clk   (clk),
      .rst_n (rst_n),
      .i_a   (w_data),
      .i_b   (w_xsel),
      .o_sum (w_lane)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         w_rd      <= 1'b0;
         w_addr    <= '0;
         out_valid <= 1'b0;
         out_z     <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         r_beat    <= '0;
         r_b1      <= '0;
         r_neuron  <= '0;
         r_v1      <= 1'b0;
         r_v2      <= 1'b0;
         r_drain   <= 1'b0;
         r_acc     <= '0;
      end else begin
         r_v1 <= w_rd;
         r_b1 <= r_beat;
         r_v2 <= r_v1;
         if (r_v2) r_acc <= w_acc_next;

         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_x      <= in_x;
                  r_neuron <= '0;
                  r_beat   <= '0;
                  r_acc    <= '0;
                  w_addr   <= '0;
                  w_rd     <= 1'b1;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               // Rows are laid out neuron-major, so the address just keeps counting
               w_addr <= w_addr + AW'(1);
               if (w_last_beat) begin
                  w_rd    <= 1'b0;
                  r_beat  <= '0;
                  r_drain <= 1'b0;
                  r_state <= DRAIN;
               end else begin
                  r_beat <= r_beat + c_bw'(1);
               end
            end
            DRAIN: begin
               r_drain <= ~r_drain;
               if (r_drain) begin
                  out_valid <= 1'b1;
                  out_z     <= w_res;
                  out_idx   <= r_neuron;
                  out_last  <= w_last_neuron;
                  r_state   <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (w_last_neuron) begin
                     in_ready <= 1'b1;
                     busy     <= 1'b0;
                     w_addr   <= '0;
                     r_state  <= IDLE;
                  end else begin
                     r_neuron <= r_neuron + IW'(1);
                     r_beat   <= '0;
                     r_acc    <= '0;
                     w_rd     <= 1'b1;
                     r_state  <= RUN;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fc_mac_neuron_seq.sv
`default_nettype none
// ============================================================================
// tb_fc_mac_neuron_seq : table vectors plus queued scoreboard for the FC layer
// Revision : 1.0
// ============================================================================
module tb_fc_mac_neuron_seq;
   import fc_pkg::*;

   localparam int P_W     = 8;
   localparam int P_IN    = 128;
   localparam int P_N     = 10;
   localparam int P_L     = 8;
   localparam int P_BEATS = P_IN / P_L;
   localparam int P_NB    = P_N * P_BEATS;
   localparam int P_ACC   = 2*P_W + $clog2(P_IN);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_n, in_valid, in_ready, w_rd, out_valid, out_ready, out_last, busy;
   logic [P_IN*P_W-1:0]    in_x;
   logic [7:0]             w_addr;
   logic [P_L*P_W-1:0]     w_data;
   logic [P_ACC-1:0]       out_z;
   logic [3:0]             out_idx;

   fc_mac_neuron_seq #(.WIDTH(P_W), .IN(P_IN), .NEURONS(P_N), .LANES(P_L)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_z(out_z), .out_idx(out_idx), .out_last(out_last), .busy(busy));

   // Corner 1: NEURONS=1, LANES=IN=5 (BEATS=1, odd tree). Corner 2: LANES=1, IN=3, NEURONS=2.
   logic        c1_in_valid, c1_in_ready, c1_w_rd, c1_out_valid, c1_out_last, c1_busy;
   logic [39:0] c1_in_x, c1_w_data, c1_rom;
   logic [0:0]  c1_w_addr, c1_out_idx;
   logic [18:0] c1_out_z;
   logic        c2_in_valid, c2_in_ready, c2_w_rd, c2_out_valid, c2_out_last, c2_busy;
   logic [23:0] c2_in_x;
   logic [7:0]  c2_w_data;
   logic [7:0]  c2_rom [6];
   logic [2:0]  c2_w_addr;
   logic [0:0]  c2_out_idx;
   logic [17:0] c2_out_z;

   fc_mac_neuron_seq #(.WIDTH(8), .IN(5), .NEURONS(1), .LANES(5)) dut_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(c1_in_valid), .in_ready(c1_in_ready), .in_x(c1_in_x),
      .w_rd(c1_w_rd), .w_addr(c1_w_addr), .w_data(c1_w_data), .out_valid(c1_out_valid),
      .out_ready(1'b1), .out_z(c1_out_z), .out_idx(c1_out_idx), .out_last(c1_out_last), .busy(c1_busy));

   fc_mac_neuron_seq #(.WIDTH(8), .IN(3), .NEURONS(2), .LANES(1)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .in_valid(c2_in_valid), .in_ready(c2_in_ready), .in_x(c2_in_x),
      .w_rd(c2_w_rd), .w_addr(c2_w_addr), .w_data(c2_w_data), .out_valid(c2_out_valid),
      .out_ready(1'b1), .out_z(c2_out_z), .out_idx(c2_out_idx), .out_last(c2_out_last), .busy(c2_busy));

   // Weight ROMs with one cycle of read latency
   logic [P_L*P_W-1:0] rom [P_NB];
   always @(posedge clk) begin
      if (w_rd)    w_data    <= rom[w_addr];
      if (c1_w_rd) c1_w_data <= c1_rom;
      if (c2_w_rd) c2_w_data <= c2_rom[c2_w_addr];
   end

   int n_chk = 0, n_err = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint relu(input longint s);
`ifdef FC_RELU_EN
      return (s < 0) ? 0 : s;
`else
      return s;
`endif
   endfunction

   function automatic longint model(input logic [P_IN*P_W-1:0] x, input int n);
      longint s = 0;
      logic [P_L*P_W-1:0] row;
      for (int i = 0; i < P_IN; i++) begin
         row = rom[n*P_BEATS + i/P_L];
         s += longint'($signed(x[i*P_W +: P_W])) * longint'($signed(row[(i%P_L)*P_W +: P_W]));
      end
      return relu(s);
   endfunction

   typedef struct { longint z; int idx; bit last; } exp_t;
   exp_t   q[$];
   exp_t   mon_e;
   int     n_acc = 0, n_hs = 0, exp_addr = 0, c2_exp = 0;
   longint got_z [16];
   bit     hold = 1'b0;
   logic [P_ACC-1:0] hold_z;
   logic [3:0]       hold_idx;
   bit     rdy_mode = 1'b1;

   // Scoreboard push: expected results for every accepted vector
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         n_acc++;
         for (int n = 0; n < P_N; n++) q.push_back('{model(in_x, n), n, (n == P_N - 1)});
      end
   end

   always @(posedge clk) begin
      #1;
      out_ready = rdy_mode ? 1'b1 : ($urandom_range(0, 99) < 30);
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         hold = 1'b0;
         exp_addr = 0;
         c2_exp = 0;
      end else begin
         if (w_rd) begin
            check("w_addr", w_addr, exp_addr);
            exp_addr = (exp_addr + 1) % P_NB;
         end
         if (c1_w_rd) check("c1_w_addr", c1_w_addr, 0);
         if (c2_w_rd) begin
            check("c2_w_addr", c2_w_addr, c2_exp);
            c2_exp = (c2_exp + 1) % 6;
         end
         if (hold && out_valid) begin
            check("stall_z_stable", out_z, hold_z);
            check("stall_idx_stable", out_idx, hold_idx);
            check("stall_no_w_rd", w_rd, 0);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_chk++; n_err++;
               $display("FAIL out_unexpected: got idx %0d expected no result", out_idx);
            end else begin
               mon_e = q.pop_front();
               check("out_z", $signed(out_z), mon_e.z);
               check("out_idx", out_idx, mon_e.idx);
               check("out_last", out_last, mon_e.last);
               got_z[out_idx] = $signed(out_z);
               n_hs++;
            end
         end
         hold     = out_valid && !out_ready;
         hold_z   = out_z;
         hold_idx = out_idx;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [P_IN*P_W-1:0] x);
      int t = 0;
      while (!in_ready && t < 5000) begin tick(); t++; end
      check("in_ready_before_send", in_ready, 1);
      in_x = x; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int t = 0;
      while ((q.size() != 0 || !in_ready) && t < budget) begin tick(); t++; end
      check("layer_done", (q.size() == 0 && in_ready), 1);
   endtask

   task automatic fill_rom_const(input int wv);
      for (int r = 0; r < P_NB; r++)
         for (int k = 0; k < P_L; k++) rom[r][k*P_W +: P_W] = P_W'(wv);
   endtask

   task automatic fill_rom_rand();
      for (int r = 0; r < P_NB; r++)
         for (int k = 0; k < P_L; k++) rom[r][k*P_W +: P_W] = P_W'($urandom);
   endtask

   function automatic logic [P_IN*P_W-1:0] vec_const(input int xv);
      logic [P_IN*P_W-1:0] v;
      for (int i = 0; i < P_IN; i++) v[i*P_W +: P_W] = P_W'(xv);
      return v;
   endfunction

   function automatic logic [P_IN*P_W-1:0] vec_rand();
      logic [P_IN*P_W-1:0] v;
      for (int i = 0; i < P_IN; i++) v[i*P_W +: P_W] = P_W'($urandom);
      return v;
   endfunction

   typedef struct { int xv; int wv; longint exp_z; } vec_t;
   vec_t tbl [6];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [P_IN*P_W-1:0] va, vb;
      longint s;
      int cyc, t, n0, hs0;

      tbl[0] = '{1, 1, 128};
      tbl[1] = '{-128, -128, 2097152};
      tbl[2] = '{-128, 127, relu(-2080768)};
      tbl[3] = '{3, -2, relu(-768)};
      tbl[4] = '{127, 127, 2064512};
      tbl[5] = '{0, -77, 0};

      rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
      c1_in_valid = 1'b0; c1_in_x = '0; c1_rom = '0;
      c2_in_valid = 1'b0; c2_in_x = '0;
      for (int r = 0; r < 6; r++) c2_rom[r] = '0;
      fill_rom_const(0);
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_w_rd", w_rd, 0);
      check("rst_out_z", out_z, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_out_last", out_last, 0);
      check("rst_w_addr", w_addr, 0);
      rst_n = 1'b1;
      tick();

      // Uniform vectors with closed-form results, incl. accumulator extremes
      for (int i = 0; i < 6; i++) begin
         fill_rom_const(tbl[i].wv);
         for (int n = 0; n < 16; n++) got_z[n] = -1;
         hs0 = n_hs;
         in_x = vec_const(tbl[i].xv); in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         cyc = 1;
         while (!in_ready && cyc < 1000) begin tick(); cyc++; end
         if (i == 0) check("accept_to_idle_cycles", cyc, 1 + P_N*(P_BEATS + 3));
         wait_done(100);
         check("table_results", n_hs - hs0, P_N);
         for (int n = 0; n < P_N; n++) check("table_z", got_z[n], tbl[i].exp_z);
      end

      // Reset while neuron 3 is issuing beat 5
      fill_rom_rand();
      send(vec_rand());
      t = 0;
      while (!(w_rd && w_addr == 8'(3*P_BEATS + 5)) && t < 2000) begin tick(); t++; end
      check("reached_n3_b5", (w_rd && w_addr == 8'(3*P_BEATS + 5)), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_w_rd", w_rd, 0);
      send(vec_rand());
      wait_done(1000);

      // Random data under 30% out_ready
      rdy_mode = 1'b0;
      for (int k = 0; k < 2; k++) begin
         fill_rom_rand();
         send(vec_rand());
         wait_done(20000);
      end
      rdy_mode = 1'b1;
      tick();

      // in_valid held high with a changing vector across a whole layer
      fill_rom_rand();
      va = vec_rand();
      vb = vec_rand();
      in_x = va; in_valid = 1'b1;
      tick();
      n0 = n_acc;
      in_x = vb;
      t = 0;
      while (!(out_valid && out_last && out_ready) && t < 1000) begin tick(); t++; end
      check("held_valid_final_out", (out_valid && out_last), 1);
      check("held_valid_no_early_accept", n_acc, n0);
      tick();
      check("held_valid_idle_after_hs", in_ready, 1);
      check("held_valid_not_yet", n_acc, n0);
      tick();
      check("held_valid_second_accept", n_acc, n0 + 1);
      check("held_valid_busy_again", in_ready, 0);
      in_valid = 1'b0;
      wait_done(1000);

      // Corner 1: single neuron, single beat, odd-width adder tree
      for (int i = 0; i < 5; i++) begin
         c1_in_x[i*8 +: 8] = 8'($urandom);
         c1_rom[i*8 +: 8]  = 8'($urandom);
      end
      s = 0;
      for (int i = 0; i < 5; i++) s += longint'($signed(c1_in_x[i*8 +: 8])) * longint'($signed(c1_rom[i*8 +: 8]));
      c1_in_valid = 1'b1;
      tick();
      c1_in_valid = 1'b0;
      cyc = 0;
      while (!c1_out_valid && cyc < 50) begin tick(); cyc++; end
      check("c1_latency", cyc, 3);
      check("c1_out_z", $signed(c1_out_z), relu(s));
      check("c1_out_idx", c1_out_idx, 0);
      check("c1_out_last", c1_out_last, 1);
      tick();
      check("c1_idle", c1_in_ready, 1);

      // Corner 2: one lane, three beats per neuron, two neurons
      for (int i = 0; i < 3; i++) c2_in_x[i*8 +: 8] = 8'($urandom);
      for (int r = 0; r < 6; r++) c2_rom[r] = 8'($urandom);
      c2_in_valid = 1'b1;
      tick();
      c2_in_valid = 1'b0;
      for (int n = 0; n < 2; n++) begin
         s = 0;
         for (int i = 0; i < 3; i++) s += longint'($signed(c2_in_x[i*8 +: 8])) * longint'($signed(c2_rom[n*3 + i]));
         cyc = 0;
         while (!c2_out_valid && cyc < 50) begin tick(); cyc++; end
         check("c2_latency", cyc, 5);
         check("c2_out_z", $signed(c2_out_z), relu(s));
         check("c2_out_idx", c2_out_idx, n);
         check("c2_out_last", c2_out_last, (n == 1));
         tick();
      end
      check("c2_idle", c2_in_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
